// File: rtl/ssd_msg_scroller.sv
// Message buffer and left-scroller for the 8-digit seven-segment driver.
// Holds up to MSG_MAX glyphs and emits a registered 8-digit window of them.
module ssd_msg_scroller #(
  parameter int CLK_DIV = 25_000_000,
  parameter int MSG_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [3:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        run,
  output logic [31:0] win_codes,
  output logic        win_valid,
  output logic [4:0]  msg_len
);

  localparam int AW = $clog2(MSG_MAX);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);
  localparam logic [4:0] WP_TOP = 5'(MSG_MAX - 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    SHOW,
    SCROLL
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      wp_q, wp_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      off_q, off_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mem_q [MSG_MAX];
  logic [3:0]      mem_d [MSG_MAX];
  logic [31:0]     win_q, win_d;
  logic            wvalid_q, wvalid_d;
  logic            accept;

  logic [4:0]      ring;
  logic [4:0]      pos;
  logic [4:0]      idx;
  logic [3:0]      g;

  assign wr_ready  = (state_q == EMPTY) || (state_q == LOAD);
  assign accept    = wr_en & wr_ready;
  assign win_codes = win_q;
  assign win_valid = wvalid_q;
  assign msg_len   = len_q;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    len_d   = len_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (clr) begin
      state_d = EMPTY;
      wp_d    = '0;
      len_d   = '0;
      off_d   = '0;
      cnt_d   = '0;
      for (int i = 0; i < MSG_MAX; i++) begin
        mem_d[i] = 4'hF;
      end
    end else begin
      unique case (state_q)
        EMPTY, LOAD: begin
          if (accept) begin
            mem_d[wp_q[AW-1:0]] = wr_data;
            wp_d    = wp_q + 5'd1;
            state_d = LOAD;
            if (wr_last || (wp_q == WP_TOP)) begin
              len_d   = wp_q + 5'd1;
              state_d = (wp_q < 5'd8) ? SHOW : SCROLL;
              off_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        SCROLL: begin
          if (run) begin
            if (cnt_q == CNT_TOP) begin
              cnt_d = '0;
              // offset runs 0..len, the extra slot being the blank separator
              off_d = (off_q == len_q) ? 5'd0 : off_q + 5'd1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win_d    = 32'hFFFF_FFFF;
    wvalid_d = 1'b0;
    ring     = len_q + 5'd1;
    pos      = '0;
    idx      = '0;
    g        = 4'hF;
    if (!clr) begin
      for (int k = 0; k < 8; k++) begin
        pos = 5'(7 - k);
        idx = off_q + pos;
        if (idx >= ring) begin
          idx = idx - ring;
        end
        unique case (state_q)
          SHOW:    g = (pos < len_q) ? mem_q[pos[AW-1:0]] : 4'hF;
          SCROLL:  g = (idx == len_q) ? 4'hF : mem_q[idx[AW-1:0]];
          default: g = 4'hF;
        endcase
        win_d[4*k +: 4] = g;
      end
      wvalid_d = (state_q == SHOW) || (state_q == SCROLL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wp_q     <= '0;
      len_q    <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      win_q    <= 32'hFFFF_FFFF;
      wvalid_q <= 1'b0;
      for (int i = 0; i < MSG_MAX; i++) begin
        mem_q[i] <= 4'hF;
      end
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      len_q    <= len_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      wvalid_q <= wvalid_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ssd_msg_scroller.sv
// Self-checking bench for ssd_msg_scroller with CLK_DIV = 4.
// Compares every cycle against a queue-based message/offset model.
module tb_ssd_msg_scroller;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_data = '0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        run = 1'b1;
  logic [31:0] win_codes;
  logic        win_valid;
  logic [4:0]  msg_len;

  int n_chk = 0;
  int n_fail = 0;

  int msg [$];
  int m_mode = 0;
  int m_len = 0;
  int m_act = 0;

  ssd_msg_scroller #(.CLK_DIV(CD), .MSG_MAX(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_ready(wr_ready),
    .run(run),
    .win_codes(win_codes),
    .win_valid(win_valid),
    .msg_len(msg_len)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    msg.delete();
    m_mode = 0;
    m_len = 0;
    m_act = 0;
  endtask

  // mode 0: no message shown, 1: static, 2: scrolling
  function automatic logic [31:0] model_win();
    logic [31:0] w;
    int r, off, p, gl;
    w = '1;
    if (m_mode == 0) return w;
    r = m_len + 1;
    off = (m_act / CD) % r;
    for (int j = 0; j < 8; j++) begin
      if (m_mode == 1) begin
        gl = (j < m_len) ? msg[j] : 15;
      end else begin
        p = (off + j) % r;
        gl = (p == m_len) ? 15 : msg[p];
      end
      w = {w[27:0], 4'(gl)};
    end
    return w;
  endfunction

  task automatic cyc();
    logic [31:0] ew;
    logic ev;
    ew = clr ? 32'hFFFF_FFFF : model_win();
    ev = !clr && (m_mode != 0);
    if (clr) begin
      model_reset();
    end else if (wr_en && m_mode == 0) begin
      msg.push_back(int'(wr_data));
      if (wr_last || msg.size() == 16) begin
        m_len = msg.size();
        m_mode = (m_len <= 8) ? 1 : 2;
        m_act = 0;
      end
    end else if (m_mode == 2 && run) begin
      m_act++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("win_codes", win_codes, ew);
    chk("win_valid", 32'(win_valid), 32'(ev));
    chk("wr_ready", 32'(wr_ready), 32'(m_mode == 0));
    chk("msg_len", 32'(msg_len), 32'(m_len));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(logic [3:0] d, logic l);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = l;
    cyc();
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    int len;
    #12;
    chk("rst_win", win_codes, 32'hFFFF_FFFF);
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_len", 32'(msg_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    idle(2);

    for (int i = 0; i < 12; i++) write(4'(i + 2), i == 11);
    idle(9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_win", win_codes, 32'hFFFF_FFFF);
    chk("async_valid", 32'(win_valid), 32'd0);
    chk("async_ready", 32'(wr_ready), 32'd1);
    chk("async_len", 32'(msg_len), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    write(4'h3, 1'b0);
    write(4'h1, 1'b0);
    write(4'h4, 1'b1);
    cyc();
    chk("reload_win", win_codes, 32'h314F_FFFF);

    do_clr();
    write(4'h7, 1'b0);
    write(4'h6, 1'b0);
    write(4'h5, 1'b1);
    cyc();
    chk("short_win", win_codes, 32'h765F_FFFF);
    idle(10 * CD);
    chk("short_hold", win_codes, 32'h765F_FFFF);

    do_clr();
    for (int i = 0; i < 10; i++) write(4'(i), i == 9);
    cyc();
    chk("scroll_s0", win_codes, 32'h0123_4567);
    idle(4);
    chk("scroll_s1", win_codes, 32'h1234_5678);
    idle(8);
    chk("scroll_s3", win_codes, 32'h3456_789F);
    idle(32);
    chk("scroll_s11", win_codes, 32'h0123_4567);

    do_clr();
    for (int i = 0; i < 16; i++) write(4'($urandom_range(0, 15)), 1'b0);
    chk("cap_len", 32'(msg_len), 32'd16);
    write(4'h0, 1'b1);
    idle(17 * CD + 4);

    do_clr();
    for (int i = 0; i < 12; i++) write(4'(i), 1'b0);
    write(4'hC, 1'b1);
    idle(6);
    run = 1'b0;
    idle(20);
    run = 1'b1;
    idle(10);

    do_clr();
    write(4'h1, 1'b0);
    write(4'h2, 1'b0);
    clr = 1'b1;
    wr_en = 1'b1;
    wr_data = 4'h3;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    wr_en = 1'b0;
    write(4'hA, 1'b0);
    write(4'hB, 1'b1);
    cyc();
    chk("clr_wr_win", win_codes, 32'hABFF_FFFF);

    for (int r = 0; r < 6; r++) begin
      do_clr();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        write(4'($urandom_range(0, 15)),
              (i == len - 1) ? ((len == 16) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
        run = ($urandom_range(0, 3) != 0);
        wr_en = 1'($urandom_range(0, 1));
        wr_data = 4'($urandom_range(0, 15));
        cyc();
      end
      wr_en = 1'b0;
      run = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
